// File: rtl/pwm_pkg.sv
// Shared definitions for the switch-driven PWM generator: duty/switch widths,
// the switch-to-duty scale shift and the duty-ramp FSM state type.
package pwm_pkg;

  localparam int DUTY_W         = 8;
  localparam int SW_W           = 4;
  localparam int SW_SCALE_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a candidate/counter debouncer. A new
// switch value is accepted only after DEBOUNCE_CYCLES consecutive identical
// synchronised samples; shorter glitches never reach sw_stable_o.
module sw_debounce #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sw_stable_o
);

  localparam int             CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     meta_q, sync_q;
  logic [W-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     stable_q, stable_d;

  // Restart the count on any change; commit once the count reaches its top.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) stable_d = cand_q;
    end
  end

  // Synchroniser chain and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      meta_q   <= sw_i;
      sync_q   <= meta_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sw_stable_o = stable_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Converts the debounced switch bank into the PWM duty value. Duty moves
// toward target = sw_stable * 16 only on PWM period wraps.
// Build option: define PWM_DUTY_RAMP_EN to slew by RAMP_STEP per wrap;
// without it the duty jumps straight to the target on the next wrap.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_STEP       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic              period_wrap,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_update,
  output logic              busy
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("pwm_duty_ramp: DEBOUNCE_CYCLES must be >= 2");
  end
  if (RAMP_STEP < 1 || RAMP_STEP > 240) begin : g_bad_step
    $error("pwm_duty_ramp: RAMP_STEP must be in 1..240");
  end

  logic [SW_W-1:0]   sw_stable;
  logic [DUTY_W-1:0] target;
  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              duty_update_q;

  sw_debounce #(
    .W               (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk         (clk),
    .rst         (rst),
    .sw_i        (sw),
    .sw_stable_o (sw_stable)
  );

  // Target is the registered switch value scaled up; top value is 240.
  assign target = {sw_stable, {SW_SCALE_SHIFT{1'b0}}};

`ifdef PWM_DUTY_RAMP_EN
  localparam logic [DUTY_W:0]   STEP_W = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] STEP_N = DUTY_W'(RAMP_STEP);

  // 9-bit distances so no comparison can wrap around.
  logic [DUTY_W:0] dist_up, dist_dn;
  assign dist_up = {1'b0, target} - {1'b0, duty_q};
  assign dist_dn = {1'b0, duty_q} - {1'b0, target};
`endif

  // Direction is re-evaluated every cycle; duty only moves on a wrap.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      IDLE: begin
        if (target > duty_q)      state_d = RAMP_UP;
        else if (target < duty_q) state_d = RAMP_DOWN;
      end
      default: begin
        if (target == duty_q) begin
          state_d = IDLE;
`ifdef PWM_DUTY_RAMP_EN
        end else if (target > duty_q && state_q != RAMP_UP) begin
          state_d = RAMP_UP;
        end else if (target < duty_q && state_q != RAMP_DOWN) begin
          state_d = RAMP_DOWN;
        end else if (period_wrap) begin
          if (state_q == RAMP_UP) begin
            if (dist_up <= STEP_W) begin
              duty_d  = target;
              state_d = IDLE;
            end else begin
              duty_d = duty_q + STEP_N;
            end
          end else begin
            if (dist_dn <= STEP_W) begin
              duty_d  = target;
              state_d = IDLE;
            end else begin
              duty_d = duty_q - STEP_N;
            end
          end
        end
`else
        end else if (period_wrap) begin
          duty_d  = target;
          state_d = IDLE;
        end
`endif
      end
    endcase
  end

  // State, duty register and a one-cycle pulse whenever duty actually moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      duty_q        <= '0;
      duty_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      duty_update_q <= (duty_d != duty_q);
    end
  end

  assign duty        = duty_q;
  assign duty_update = duty_update_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Upstream stage of the switch-driven PWM generator: converts the raw 4-bit switch bank into the 8-bit duty value the PWM comparator consumes. It synchronises and debounces the switches and scales them to a target duty (sw × 16, 0–240). It then slews the output duty toward that target by a fixed step. Duty changes only on PWM period boundaries, so the comparator never sees a mid-period update.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples needed to accept a new switch value; legal range ≥ 2.
- `RAMP_STEP`, default 1: duty increment/decrement applied per PWM period while ramping; legal range 1–240.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sw` input 4: raw asynchronous switch inputs.
- `period_wrap` input 1: single-cycle pulse from the PWM stage when its 8-bit counter wraps 255→0.
- `duty` output 8: registered duty value for the PWM comparator.
- `duty_update` output 1: high for exactly one cycle, in the same cycle `duty` first shows a new value.
- `busy` output 1: high while `duty` ≠ current target.

## Operation
- Reset (`rst`=1 at a rising edge) sets the following, regardless of any in-progress debounce or ramp:
  - sync flops, `sw_stable`, debounce counter, `duty` and `duty_update` to 0;
  - state to IDLE.
  - `busy` is 0 because duty equals target (0).
- Synchroniser: `sw` passes through a 2-flop chain, giving `sw_sync`.
- Debounce:
  - Candidate register plus a counter.
  - If `sw_sync` ≠ candidate, load the candidate and clear the counter.
  - Otherwise increment the counter, saturating.
  - When the counter reaches DEBOUNCE_CYCLES−1, commit the candidate to `sw_stable`.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are never committed.
- Target: `target = {sw_stable, 4'b0000}`, computed with 8-bit unsigned arithmetic; max 240, never 255.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
  - IDLE: `duty` = target. Go to RAMP_UP if target > duty, or RAMP_DOWN if target < duty, evaluated every cycle.
  - RAMP_UP, on `period_wrap`:
    - if target − duty ≤ RAMP_STEP: `duty` ← target, then IDLE;
    - else `duty` ← duty + RAMP_STEP.
  - RAMP_DOWN, on `period_wrap`: mirror of RAMP_UP using duty − target. `duty` never underflows below target or 0.
  - Target change while ramping: direction is re-evaluated every cycle. Swap RAMP_UP/RAMP_DOWN, or go to IDLE if target == duty, before the next step is applied.
- Differences are computed 9-bit wide; no wrap-around is permitted.
- `duty_update` asserts only when the `duty` register value actually changes.

## Timing
- Switch change to `sw_stable` change: 2 sync cycles + DEBOUNCE_CYCLES cycles, for a switch held stable throughout.
- `sw_stable` to `busy` high: 1 cycle, via the state register.
- Duty update: applied on the rising edge at which `period_wrap`=1. `duty` and `duty_update` are valid in the following cycle.
- No `period_wrap` means `duty` is frozen and `busy` stays high.
- Continuous `period_wrap`=1 gives one step per cycle (a legal stress case).
- Simultaneous target change and `period_wrap`: the step uses the target registered before that edge.
- Full ramp 0→240 with RAMP_STEP=1: 240 wraps.

## Configuration
- Macro `PWM_DUTY_RAMP_EN`.
- Defined: ramping as specified above.
- Undefined:
  - no RAMP_UP/RAMP_DOWN stepping; `duty` ← target in one step on the first `period_wrap` after the target changes;
  - `busy` is high from the target change until that step;
  - RAMP_STEP is ignored.
- Debounce and the boundary alignment behave the same in both builds.

## Structure
- Shared package `pwm_pkg` holds:
  - `DUTY_W`=8 and `SW_W`=4;
  - the FSM state typedef (IDLE/RAMP_UP/RAMP_DOWN, 2-bit);
  - `SW_SCALE_SHIFT`=4.
  - The PWM stage imports the same `DUTY_W`.
- One sub-module, `sw_debounce`: synchroniser, candidate register and counter, parameterised by width and DEBOUNCE_CYCLES, output `sw_stable`.
- The ramp FSM and duty register live in the top level.

## Test plan
- Reset: drive `rst`=1 mid-ramp with `duty`=0x50. Next cycle, `duty`=0, `busy`=0, `duty_update`=0, and the FSM is in IDLE.
- Debounce:
  - `sw` pulse 4'h3 lasting 10 cycles (DEBOUNCE_CYCLES=16): target stays 0, `busy` never rises.
  - `sw` held at 4'h3: `busy` rises 19 cycles after the change.
- Ramp up, `sw`=4'hF, RAMP_STEP=16, `period_wrap` every 256 cycles: `duty` steps 16, 32, …, 240.
  - One `duty_update` pulse per wrap; 15 pulses total.
  - `busy` falls in the cycle `duty`=240 appears.
- Ramp down with saturation, RAMP_STEP=7, from `duty`=32 toward target 0: `duty` goes 25, 18, 11, 4, 0, and never underflows.
- Reversal: ramping up at `duty`=0x40, `sw` changes to 4'h2. After debounce, the FSM enters RAMP_DOWN and the next wrap yields 0x40−RAMP_STEP.
- Build without `PWM_DUTY_RAMP_EN`: `sw` 0→4'hA. `duty` jumps 0→160 on the first `period_wrap` after debounce, with a single `duty_update` pulse.
